// File: rtl/serial_pkg.sv
// Shared types and defaults for the serial transmit slice.
// Parity support in serial_tx is selected by the SERIAL_TX_PARITY_EN macro.
package serial_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
    StParity,
    StStop
  } serial_state_e;

  localparam int unsigned SERIAL_DATA_W       = 8;
  localparam int unsigned SERIAL_CLKS_PER_BIT = 16;

  // Frame length in clocks: start + data + optional parity + stop.
  function automatic int unsigned frame_len(input int unsigned data_w,
                                            input int unsigned clks_per_bit,
                                            input bit          parity_en);
    return (data_w + 2 + (parity_en ? 1 : 0)) * clks_per_bit;
  endfunction

endpackage

// File: rtl/serial_baud_gen.sv
// Bit-period counter: counts 0..CLKS_PER_BIT-1 while enabled and pulses bit_tick on the
// final count of each period.
module serial_baud_gen #(
  parameter int unsigned CLKS_PER_BIT = 16,
  localparam int unsigned CntW = $clog2(CLKS_PER_BIT)
) (
  input  logic            Clock,
  input  logic            Reset,
  input  logic            enable,
  input  logic            clear,
  output logic [CntW-1:0] count,
  output logic            bit_tick
);

  localparam logic [CntW-1:0] MaxCnt = CntW'(CLKS_PER_BIT - 1);

  logic [CntW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (enable) begin
      cnt_d = (cnt_q == MaxCnt) ? '0 : cnt_q + CntW'(1);
    end
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign count    = cnt_q;
  assign bit_tick = enable && (cnt_q == MaxCnt);

endmodule

// File: rtl/serial_tx.sv
// Parallel-to-serial transmitter: start bit, LSB-first data, optional even parity, stop bit.
// Define SERIAL_TX_PARITY_EN to compile in the parity bit.
module serial_tx
  import serial_pkg::*;
#(
  parameter int unsigned DATA_W       = SERIAL_DATA_W,
  parameter int unsigned CLKS_PER_BIT = SERIAL_CLKS_PER_BIT
) (
  input  logic              Clock,
  input  logic              Reset,
  input  logic [DATA_W-1:0] Data,
  input  logic              Valid,
  output logic              Ready,
  output logic              TxOut,
  output logic              Busy,
  output logic              Done
);

  localparam int unsigned CntW = $clog2(CLKS_PER_BIT);
  localparam int unsigned BitW = $clog2(DATA_W + 1);
  localparam logic [BitW-1:0] LastBit = BitW'(DATA_W - 1);
  // Done is registered, so it is launched one count before the stop bit's final clock.
  localparam logic [CntW-1:0] DoneCnt = CntW'(CLKS_PER_BIT - 2);

  serial_state_e     state_q, state_d;
  logic [DATA_W-1:0] shift_q, shift_d;
  logic [BitW-1:0]   bit_cnt_q, bit_cnt_d;
  logic              tx_q, tx_d;
  logic              ready_q, ready_d;
  logic              busy_q;
  logic              done_q, done_d;
`ifdef SERIAL_TX_PARITY_EN
  logic              parity_q, parity_d;
`endif

  logic [CntW-1:0] baud_cnt;
  logic            bit_tick;
  logic            baud_en;

  assign baud_en = (state_q != StIdle);

  serial_baud_gen #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud (
    .Clock   (Clock),
    .Reset   (Reset),
    .enable  (baud_en),
    .clear   (!baud_en),
    .count   (baud_cnt),
    .bit_tick(bit_tick)
  );

  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    bit_cnt_d = bit_cnt_q;
    tx_d      = tx_q;
    done_d    = 1'b0;
`ifdef SERIAL_TX_PARITY_EN
    parity_d  = parity_q;
`endif
    unique case (state_q)
      StIdle: begin
        tx_d = 1'b1;
        if (Valid && ready_q) begin
          state_d   = StStart;
          shift_d   = Data;
          bit_cnt_d = '0;
          tx_d      = 1'b0;
`ifdef SERIAL_TX_PARITY_EN
          parity_d  = ^Data;
`endif
        end
      end
      StStart: begin
        if (bit_tick) begin
          state_d = StData;
          tx_d    = shift_q[0];
        end
      end
      StData: begin
        if (bit_tick) begin
          shift_d   = shift_q >> 1;
          bit_cnt_d = bit_cnt_q + BitW'(1);
          if (bit_cnt_q == LastBit) begin
`ifdef SERIAL_TX_PARITY_EN
            state_d = StParity;
            tx_d    = parity_q;
`else
            state_d = StStop;
            tx_d    = 1'b1;
`endif
          end else begin
            tx_d = shift_d[0];
          end
        end
      end
      StParity: begin
`ifdef SERIAL_TX_PARITY_EN
        if (bit_tick) begin
          state_d = StStop;
          tx_d    = 1'b1;
        end
`else
        state_d = StIdle;
`endif
      end
      StStop: begin
        done_d = (baud_cnt == DoneCnt);
        if (bit_tick) begin
          state_d   = StIdle;
          tx_d      = 1'b1;
          bit_cnt_d = '0;
        end
      end
      default: state_d = StIdle;
    endcase
    ready_d = (state_d == StIdle);
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state_q   <= StIdle;
      shift_q   <= '0;
      bit_cnt_q <= '0;
      tx_q      <= 1'b1;
      ready_q   <= 1'b1;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
`ifdef SERIAL_TX_PARITY_EN
      parity_q  <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      shift_q   <= shift_d;
      bit_cnt_q <= bit_cnt_d;
      tx_q      <= tx_d;
      ready_q   <= ready_d;
      busy_q    <= !ready_d;
      done_q    <= done_d;
`ifdef SERIAL_TX_PARITY_EN
      parity_q  <= parity_d;
`endif
    end
  end

  assign Ready = ready_q;
  assign Busy  = busy_q;
  assign TxOut = tx_q;
  assign Done  = done_q;

endmodule
